outport_vc_arbiter: RTL and testbench

// Next-generation switch output port: arbitrates flits from NUM_INPORTS input buffers onto one link.
// Per-VC wormhole locking, per-VC credit counters and round-robin fairness.

---
 rtl/outport_vc_arbiter.sv | 147 ++++++++++++++
 tb/tb_outport_vc_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/outport_vc_arbiter.sv
// rtl/outport_vc_arbiter.sv - output-port flit arbiter with per-VC wormhole locks and credits
// Round-robin over inputs; a locked VC only accepts flits from its owning input.
module outport_vc_arbiter #(
  parameter int NUM_INPORTS  = 4,
  parameter int NUM_VCS      = 2,
  parameter int FLIT_W       = 32,
  parameter int CREDIT_DEPTH = 8,
  parameter int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [NUM_INPORTS-1:0]              req,
  input  logic [NUM_INPORTS-1:0][VC_W-1:0]    req_vc,
  input  logic [NUM_INPORTS-1:0][FLIT_W-1:0]  req_flit,
  input  logic [NUM_INPORTS-1:0]              req_last,
  output logic [NUM_INPORTS-1:0]              grant,
  output logic                                out_valid,
  output logic [FLIT_W-1:0]                   out_flit,
  output logic [VC_W-1:0]                     out_vc,
  output logic                                out_last,
  input  logic [NUM_VCS-1:0]                  credit_return,
  output logic [NUM_VCS-1:0][CNT_W-1:0]       credit_cnt,
  output logic [NUM_VCS-1:0]                  vc_locked,
  output logic                                credit_err
);

  localparam int IDX_W = (NUM_INPORTS > 1) ? $clog2(NUM_INPORTS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

  logic [IDX_W-1:0]                  rr_q, rr_d;
  logic [NUM_VCS-1:0]                vc_locked_q, vc_locked_d;
  logic [NUM_VCS-1:0][IDX_W-1:0]     owner_q, owner_d;
  logic [NUM_VCS-1:0][CNT_W-1:0]     credit_cnt_q, credit_cnt_d;
  logic                              credit_err_q, credit_err_d;
  logic                              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]                 out_flit_q, out_flit_d;
  logic [VC_W-1:0]                   out_vc_q, out_vc_d;
  logic                              out_last_q, out_last_d;

  logic [NUM_INPORTS-1:0]            eligible;
  logic                              found;
  logic [IDX_W-1:0]                  gidx;
  logic [IDX_W-1:0]                  cand;
  logic [VC_W-1:0]                   gvc;
  logic [NUM_VCS-1:0]                sent_vc;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_INPORTS; i++) begin
      eligible[i] = req[i] && (credit_cnt_q[req_vc[i]] != '0) &&
                    (!vc_locked_q[req_vc[i]] || (owner_q[req_vc[i]] == IDX_W'(i)));
    end

    // First eligible input at or after the round-robin pointer wins.
    found = 1'b0;
    gidx  = '0;
    cand  = '0;
    for (int off = 0; off < NUM_INPORTS; off++) begin
      cand = IDX_W'((int'(rr_q) + off) % NUM_INPORTS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    gvc = req_vc[gidx];

    grant = '0;
    if (found && nRST) begin
      grant[gidx] = 1'b1;
    end

    sent_vc = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      sent_vc[v] = found && (gvc == VC_W'(v));
    end
  end

  always_comb begin
    rr_d         = rr_q;
    vc_locked_d  = vc_locked_q;
    owner_d      = owner_q;
    credit_cnt_d = credit_cnt_q;
    credit_err_d = credit_err_q;
    out_valid_d  = found;
    out_flit_d   = out_flit_q;
    out_vc_d     = out_vc_q;
    out_last_d   = out_last_q;

    if (found) begin
      rr_d = (gidx == IDX_W'(NUM_INPORTS - 1)) ? '0 : gidx + IDX_W'(1);
      // A tail releases the VC; any other flit (re)claims it, so single-flit packets never hold it.
      vc_locked_d[gvc] = !req_last[gidx];
      if (!req_last[gidx]) begin
        owner_d[gvc] = gidx;
      end
      out_flit_d = req_flit[gidx];
      out_vc_d   = gvc;
      out_last_d = req_last[gidx];
    end

    for (int v = 0; v < NUM_VCS; v++) begin
      if (credit_return[v] && !sent_vc[v]) begin
        if (credit_cnt_q[v] == FULL) begin
          credit_err_d = 1'b1;
        end else begin
          credit_cnt_d[v] = credit_cnt_q[v] + CNT_W'(1);
        end
      end else if (sent_vc[v] && !credit_return[v]) begin
        credit_cnt_d[v] = credit_cnt_q[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_q         <= '0;
      vc_locked_q  <= '0;
      owner_q      <= '0;
      credit_cnt_q <= {NUM_VCS{FULL}};
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_flit_q   <= '0;
      out_vc_q     <= '0;
      out_last_q   <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      vc_locked_q  <= vc_locked_d;
      owner_q      <= owner_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= out_valid_d;
      out_flit_q   <= out_flit_d;
      out_vc_q     <= out_vc_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_flit   = out_flit_q;
  assign out_vc     = out_vc_q;
  assign out_last   = out_last_q;
  assign credit_cnt = credit_cnt_q;
  assign vc_locked  = vc_locked_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_outport_vc_arbiter.sv
// tb/tb_outport_vc_arbiter.sv - scoreboard bench for outport_vc_arbiter
module tb_outport_vc_arbiter;

  localparam int NI = 4;
  localparam int NV = 2;
  localparam int DEPTH = 8;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NI-1:0]     req;
  logic [NI-1:0][0:0]  req_vc;
  logic [NI-1:0][31:0] req_flit;
  logic [NI-1:0]     req_last;
  logic [NI-1:0]     grant;
  logic              out_valid;
  logic [31:0]       out_flit;
  logic [0:0]        out_vc;
  logic              out_last;
  logic [NV-1:0]     credit_return;
  logic [NV-1:0][3:0] credit_cnt;
  logic [NV-1:0]     vc_locked;
  logic              credit_err;

  outport_vc_arbiter #(
    .NUM_INPORTS(NI), .NUM_VCS(NV), .FLIT_W(32), .CREDIT_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .req_vc(req_vc), .req_flit(req_flit),
    .req_last(req_last), .grant(grant), .out_valid(out_valid), .out_flit(out_flit),
    .out_vc(out_vc), .out_last(out_last), .credit_return(credit_return),
    .credit_cnt(credit_cnt), .vc_locked(vc_locked), .credit_err(credit_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          valid;
    logic [31:0] flit;
    int          vc;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int m_cnt[NV];
  int m_owner[NV];
  int m_rr;
  bit m_err;
  logic [31:0] m_flit;
  int m_vc;
  bit m_last;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_cnt[v] = DEPTH;
      m_owner[v] = -1;
    end
    m_rr = 0;
    m_err = 0;
    m_flit = '0;
    m_vc = 0;
    m_last = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step(output int g);
    exp_t e;
    int i;
    int v;
    bit sent;
    #2;
    g = -1;
    for (int off = 0; off < NI; off++) begin
      i = (m_rr + off) % NI;
      v = int'(req_vc[i]);
      if (g < 0 && req[i] && m_cnt[v] > 0 && (m_owner[v] < 0 || m_owner[v] == i)) g = i;
    end
    chk("grant", int'(grant), (g >= 0) ? (1 << g) : 0);
    for (int k = 0; k < NV; k++) begin
      chk("credit_cnt", int'(credit_cnt[k]), m_cnt[k]);
      chk("vc_locked", int'(vc_locked[k]), int'(m_owner[k] >= 0));
    end
    chk("credit_err", int'(credit_err), int'(m_err));

    for (int k = 0; k < NV; k++) begin
      sent = (g >= 0) && (int'(req_vc[g]) == k);
      if (credit_return[k] && !sent && m_cnt[k] == DEPTH) m_err = 1;
      else m_cnt[k] = m_cnt[k] + int'(credit_return[k]) - int'(sent);
    end
    if (g >= 0) begin
      v = int'(req_vc[g]);
      m_owner[v] = req_last[g] ? -1 : g;
      m_rr = (g + 1) % NI;
      m_flit = req_flit[g];
      m_vc = v;
      m_last = req_last[g];
    end
    e.valid = (g >= 0);
    e.flit = m_flit;
    e.vc = m_vc;
    e.last = m_last;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    req = '1;
    req_vc = '0;
    req_last = '1;
    credit_return = '0;
    exp_q.delete();
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_flit", int'(out_flit), 0);
    chk("rst_cnt0", int'(credit_cnt[0]), DEPTH);
    chk("rst_cnt1", int'(credit_cnt[1]), DEPTH);
    chk("rst_locked", int'(vc_locked), 0);
    chk("rst_err", int'(credit_err), 0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    req = '0;
    req_last = '0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", int'(out_valid), int'(e.valid));
        chk("out_flit", int'(out_flit), int'(e.flit));
        chk("out_vc", int'(out_vc), e.vc);
        chk("out_last", int'(out_last), int'(e.last));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int g;
    int sent;
    int tail_c;
    int g1_c;
    bit mid;
    bit pend[NI];
    int rem[NI];
    int pvc[NI];

    nRST = 1'b0;
    req = '0;
    req_vc = '0;
    req_flit = '0;
    req_last = '0;
    credit_return = '0;
    model_reset();
    @(posedge CLK);
    #1;

    // Four single-flit VC0 requests drain in round-robin order.
    do_reset();
    req_last = '1;
    for (int i = 0; i < NI; i++) req_flit[i] = 32'h100 + 32'(i);
    req = '1;
    for (int k = 0; k < NI; k++) begin
      step(g);
      chk("t1_order", g, k);
      if (g >= 0) req[g] = 1'b0;
    end
    chk("t1_cnt0", int'(credit_cnt[0]), 4);

    // Long packet exhausts VC0 credits; one returned credit buys one flit.
    do_reset();
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      req[0] = 1'b1;
      req_vc[0] = 1'b0;
      req_flit[0] = 32'h200 + 32'(sent);
      req_last[0] = (sent == 9);
      step(g);
      if (g == 0) sent++;
    end
    chk("t2_grants", sent, 8);
    chk("t2_cnt0", int'(credit_cnt[0]), 0);
    credit_return = 2'b01;
    req_flit[0] = 32'h200 + 32'(sent);
    step(g);
    credit_return = 2'b00;
    for (int c = 0; c < 3; c++) begin
      req_flit[0] = 32'h200 + 32'(sent);
      req_last[0] = (sent == 9);
      step(g);
      if (g == 0) sent++;
    end
    chk("t2_one_more", sent, 9);
    for (int c = 0; c < 20 && sent < 10; c++) begin
      credit_return = 2'b01;
      req_flit[0] = 32'h200 + 32'(sent);
      req_last[0] = (sent == 9);
      step(g);
      if (g == 0) sent++;
    end
    chk("t2_packet_done", sent, 10);
    req = '0;
    credit_return = '0;

    // VC1 packet locks out another VC1 input while VC0 traffic interleaves.
    do_reset();
    sent = 0;
    tail_c = -1;
    g1_c = -1;
    mid = 0;
    for (int c = 0; c < 10; c++) begin
      req[0] = (sent < 3);
      req_vc[0] = 1'b1;
      req_last[0] = (sent == 2);
      req_flit[0] = 32'h300 + 32'(sent);
      req[1] = (g1_c < 0);
      req_vc[1] = 1'b1;
      req_last[1] = 1'b1;
      req_flit[1] = 32'h3A0;
      req[2] = 1'b1;
      req_vc[2] = 1'b0;
      req_last[2] = 1'b1;
      step(g);
      if (g == 2) begin
        if (sent >= 1 && sent < 3) mid = 1;
        req_flit[2] = req_flit[2] + 32'h1;
      end
      if (g == 0) begin
        sent++;
        if (sent == 3) tail_c = c;
      end
      if (g == 1) g1_c = c;
      if (sent == 1 || sent == 2) chk("t3_locked", int'(vc_locked[1]), 1);
    end
    chk("t3_tail_seen", int'(tail_c >= 0), 1);
    chk("t3_in1_after_tail", int'(g1_c > tail_c), 1);
    chk("t3_interleave", int'(mid), 1);
    req = '0;

    // Send and return on the same VC in one cycle leaves the count unchanged.
    do_reset();
    req_vc[0] = 1'b0;
    req_last[0] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req[0] = 1'b1;
      req_flit[0] = 32'h400 + 32'(c);
      step(g);
    end
    chk("t4_cnt_before", int'(credit_cnt[0]), 1);
    credit_return = 2'b01;
    req_flit[0] = 32'h4FF;
    step(g);
    credit_return = 2'b00;
    req = '0;
    chk("t4_grant", g, 0);
    chk("t4_cnt_after", int'(credit_cnt[0]), 1);
    chk("t4_no_err", int'(credit_err), 0);

    // Returning a credit to a full counter raises a sticky error.
    credit_return = 2'b10;
    step(g);
    credit_return = 2'b00;
    chk("t5_cnt1", int'(credit_cnt[1]), DEPTH);
    chk("t5_err", int'(credit_err), 1);
    for (int c = 0; c < 10; c++) step(g);
    chk("t5_err_sticky", int'(credit_err), 1);

    // Reset in the middle of a packet frees the VC for a different input.
    do_reset();
    sent = 0;
    for (int c = 0; c < 6 && sent < 2; c++) begin
      req[2] = 1'b1;
      req_vc[2] = 1'b0;
      req_last[2] = 1'b0;
      req_flit[2] = 32'h600 + 32'(sent);
      step(g);
      if (g == 2) sent++;
    end
    chk("t6_two_sent", sent, 2);
    do_reset();
    req[1] = 1'b1;
    req_vc[1] = 1'b0;
    req_last[1] = 1'b1;
    req_flit[1] = 32'h6A0;
    req[2] = 1'b1;
    req_vc[2] = 1'b0;
    req_last[2] = 1'b1;
    req_flit[2] = 32'h6B0;
    step(g);
    chk("t6_new_winner", g, 1);
    req = '0;
    step(g);

    // Randomized packet traffic on both VCs with random credit returns.
    do_reset();
    for (int i = 0; i < NI; i++) begin
      pend[i] = 0;
      rem[i] = 0;
      pvc[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!pend[i]) begin
          if (rem[i] == 0 && $urandom_range(0, 1) == 1) begin
            rem[i] = $urandom_range(1, 4);
            pvc[i] = $urandom_range(0, NV - 1);
          end
          if (rem[i] > 0 && $urandom_range(0, 3) != 0) begin
            pend[i] = 1;
            req_flit[i] = $urandom;
            req_vc[i] = 1'(pvc[i]);
            req_last[i] = (rem[i] == 1);
          end
        end
        req[i] = pend[i];
      end
      for (int v = 0; v < NV; v++) begin
        credit_return[v] = (m_cnt[v] < DEPTH && $urandom_range(0, 2) == 0) ||
                           ($urandom_range(0, 99) == 0);
      end
      step(g);
      if (g >= 0) begin
        pend[g] = 0;
        rem[g]--;
      end
    end
    req = '0;
    credit_return = '0;
    step(g);
    step(g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
